// File: rtl/aes_done_pkg.sv
// Shared types and constants for the AES completion notifier and its poll timer.
// The flag RAM word layout is {valid, status[6:0]}.
package aes_done_pkg;

  localparam int DATA_W         = 8;
  localparam int FLAG_VALID_BIT = 7;

  localparam logic [1:0] DEFAULT_FLAG_ADDR = 2'd0;
  localparam logic [1:0] DEFAULT_SEQ_ADDR  = 2'd1;

  typedef enum logic [2:0] {
    IDLE,
    WR_SEQ,
    WR_FLAG,
    WAIT,
    RD_ADDR,
    RD_DATA
  } notifier_state_e;

endpackage

// File: rtl/aes_done_poll_timer.sv
// Poll pacing for the notifier: an idle-interval countdown between flag reads
// and a count of reads issued since the flag was published.
module aes_done_poll_timer
  import aes_done_pkg::*;
#(
  parameter int POLL_INTERVAL = 16,
  parameter int TIMEOUT_POLLS = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic tick,
  input  logic rearm,
  output logic interval_done,
  output logic poll_last
);

  localparam int IW = $clog2(POLL_INTERVAL) + 1;
  localparam int PW = $clog2(TIMEOUT_POLLS) + 1;

  localparam logic [IW-1:0] INTERVAL_FULL  = IW'(POLL_INTERVAL);
  localparam logic [IW-1:0] INTERVAL_FIRST = IW'(POLL_INTERVAL - 1);
  localparam logic [PW-1:0] POLL_LAST_CNT  = PW'(TIMEOUT_POLLS - 1);

  logic [IW-1:0] interval_cnt;
  logic [PW-1:0] poll_cnt;

  // The flag-write cycle counts toward the first interval, so the first read
  // lands POLL_INTERVAL cycles after the flag write; later gaps are full length.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      interval_cnt <= '0;
      poll_cnt     <= '0;
    end else begin
      if (start)
        interval_cnt <= INTERVAL_FIRST;
      else if (rearm)
        interval_cnt <= INTERVAL_FULL;
      else if (tick && interval_cnt != '0)
        interval_cnt <= interval_cnt - IW'(1);

      if (start)
        poll_cnt <= '0;
      else if (rearm)
        poll_cnt <= poll_cnt + PW'(1);
    end
  end

  assign interval_done = (interval_cnt <= IW'(1));
  assign poll_last     = (poll_cnt == POLL_LAST_CNT);

endmodule

// File: rtl/aes_done_notifier.sv
// Publishes AES completion events (sequence number, then flag) to the shared
// done-flag RAM and polls the flag until the host clears its valid bit.
module aes_done_notifier
  import aes_done_pkg::*;
#(
  parameter int         POLL_INTERVAL = 16,
  parameter int         TIMEOUT_POLLS = 1024,
  parameter logic [1:0] FLAG_ADDR     = DEFAULT_FLAG_ADDR,
  parameter logic [1:0] SEQ_ADDR      = DEFAULT_SEQ_ADDR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              aes_done,
  input  logic [6:0]        aes_status,
  output logic              busy,
  output logic              host_ack,
  output logic              timeout,
  output logic              overflow,
  output logic [1:0]        mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              mem_clken
);

  notifier_state_e state_q, state_d;

  logic [6:0]        status_q, status_d;
  logic [6:0]        pending_status_q, pending_status_d;
  logic              pending_q, pending_d;
  logic              overflow_d;
  logic [DATA_W-1:0] seq_q;

  logic              busy_d, host_ack_d, timeout_d;
  logic [1:0]        mem_address_d;
  logic              mem_chipselect_d, mem_write_d;
  logic [DATA_W-1:0] mem_writedata_d;

  logic interval_done, poll_last;
  logic flag_valid;
  logic readdata_unused;

  assign flag_valid      = mem_readdata[FLAG_VALID_BIT];
  assign readdata_unused = ^mem_readdata[FLAG_VALID_BIT-1:0];

  aes_done_poll_timer #(
    .POLL_INTERVAL(POLL_INTERVAL),
    .TIMEOUT_POLLS(TIMEOUT_POLLS)
  ) u_poll_timer (
    .clk          (clk),
    .reset        (reset),
    .start        (state_q == WR_FLAG),
    .tick         (state_q == WAIT),
    .rearm        (state_q == RD_DATA),
    .interval_done(interval_done),
    .poll_last    (poll_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      status_q         <= '0;
      pending_status_q <= '0;
      pending_q        <= 1'b0;
      overflow         <= 1'b0;
      seq_q            <= '0;
      busy             <= 1'b0;
      host_ack         <= 1'b0;
      timeout          <= 1'b0;
      mem_address      <= '0;
      mem_chipselect   <= 1'b0;
      mem_write        <= 1'b0;
      mem_writedata    <= '0;
      mem_clken        <= 1'b0;
    end else begin
      state_q          <= state_d;
      status_q         <= status_d;
      pending_status_q <= pending_status_d;
      pending_q        <= pending_d;
      overflow         <= overflow_d;
      if (state_q == WR_SEQ)
        seq_q <= seq_q + DATA_W'(1);
      busy             <= busy_d;
      host_ack         <= host_ack_d;
      timeout          <= timeout_d;
      mem_address      <= mem_address_d;
      mem_chipselect   <= mem_chipselect_d;
      mem_write        <= mem_write_d;
      mem_writedata    <= mem_writedata_d;
      mem_clken        <= 1'b1;
    end
  end

  // A held pending event is older than a same-cycle aes_done, so it is served
  // first and the new pulse takes its place in the pending slot.
  always_comb begin
    state_d          = state_q;
    status_d         = status_q;
    pending_d        = pending_q;
    pending_status_d = pending_status_q;
    overflow_d       = overflow;

    if (state_q == IDLE && (aes_done || pending_q)) begin
      state_d = WR_SEQ;
      if (pending_q) begin
        status_d  = pending_status_q;
        pending_d = aes_done;
        if (aes_done)
          pending_status_d = aes_status;
      end else begin
        status_d = aes_status;
      end
    end else if (aes_done) begin
      if (pending_q) begin
        overflow_d = 1'b1;
      end else begin
        pending_d        = 1'b1;
        pending_status_d = aes_status;
      end
    end

    case (state_q)
      WR_SEQ:  state_d = WR_FLAG;
      WR_FLAG: state_d = WAIT;
      WAIT:    if (interval_done) state_d = RD_ADDR;
      RD_ADDR: state_d = RD_DATA;
      RD_DATA: state_d = (!flag_valid || poll_last) ? IDLE : WAIT;
      default: ;
    endcase
  end

  // Bus outputs follow the next state so they are registered yet line up with it.
  always_comb begin
    mem_address_d    = '0;
    mem_chipselect_d = 1'b0;
    mem_write_d      = 1'b0;
    mem_writedata_d  = '0;

    case (state_d)
      WR_SEQ: begin
        mem_address_d    = SEQ_ADDR;
        mem_chipselect_d = 1'b1;
        mem_write_d      = 1'b1;
        mem_writedata_d  = seq_q;
      end
      WR_FLAG: begin
        mem_address_d                   = FLAG_ADDR;
        mem_chipselect_d                = 1'b1;
        mem_write_d                     = 1'b1;
        mem_writedata_d                 = DATA_W'(status_q);
        mem_writedata_d[FLAG_VALID_BIT] = 1'b1;
      end
      RD_ADDR: begin
        mem_address_d    = FLAG_ADDR;
        mem_chipselect_d = 1'b1;
      end
      default: ;
    endcase

    busy_d     = (state_d != IDLE) || pending_d;
    host_ack_d = (state_q == RD_DATA) && !flag_valid;
    timeout_d  = (state_q == RD_DATA) && flag_valid && poll_last;
  end

endmodule

// File: tb/tb_aes_done_notifier.sv
// Directed bench for aes_done_notifier with a behavioural dual-port flag RAM
// whose host side clears the flag on a chosen read.
module tb_aes_done_notifier;

  localparam int P = 4;
  localparam int T = 4;

  typedef struct {
    int         cyc;
    logic [1:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic [6:0] status;
    int         ack_read;
    logic [7:0] exp_seq;
    logic [7:0] exp_flag;
    int         exp_reads;
    int         exp_acks;
    int         exp_tos;
    logic [7:0] exp_mem0;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       aes_done = 1'b0;
  logic [6:0] aes_status = 7'h00;
  logic       busy, host_ack, timeout, overflow;
  logic [1:0] mem_address;
  logic       mem_chipselect, mem_write, mem_clken;
  logic [7:0] mem_writedata, mem_readdata;

  logic [7:0] mem [4];
  logic [1:0] addr_q = 2'd0;
  int         rd_seen = 0;
  int         ack_on_read = 0;

  int  cyc = 0;
  wr_t wr_q[$];
  int  rd_q[$];
  int  ack_q[$];
  int  to_q[$];

  int total_checks = 0;
  int bad_checks = 0;

  vec_t vecs[4];

  aes_done_notifier #(
    .POLL_INTERVAL(P),
    .TIMEOUT_POLLS(T)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .aes_done      (aes_done),
    .aes_status    (aes_status),
    .busy          (busy),
    .host_ack      (host_ack),
    .timeout       (timeout),
    .overflow      (overflow),
    .mem_address   (mem_address),
    .mem_chipselect(mem_chipselect),
    .mem_write     (mem_write),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_clken     (mem_clken)
  );

  always #5 clk = ~clk;

  // Host side clears the flag just ahead of the ack_on_read-th poll.
  always @(posedge clk) begin
    if (mem_clken) begin
      addr_q <= mem_address;
      if (mem_chipselect && mem_write) begin
        mem[mem_address] <= mem_writedata;
        if (mem_address == 2'd0)
          rd_seen <= 0;
      end else if (mem_chipselect) begin
        rd_seen <= rd_seen + 1;
        if (ack_on_read != 0 && rd_seen + 1 == ack_on_read)
          mem[0] <= 8'h00;
      end
    end
  end

  assign mem_readdata = mem[addr_q];

  function automatic wr_t mkWr(input int c, input logic [1:0] a, input logic [7:0] d);
    mkWr.cyc  = c;
    mkWr.addr = a;
    mkWr.data = d;
  endfunction

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (mem_chipselect && mem_write)
      wr_q.push_back(mkWr(cyc + 1, mem_address, mem_writedata));
    if (mem_chipselect && !mem_write)
      rd_q.push_back(cyc + 1);
    if (host_ack)
      ack_q.push_back(cyc + 1);
    if (timeout)
      to_q.push_back(cyc + 1);
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_checks++;
    if (got !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, got, exp);
    end
  endtask

  task automatic noteFail(input string name);
    total_checks++;
    bad_checks++;
    $display("[TB] FAIL %s actual=bound_expired required=event", name);
  endtask

  task automatic firePulse(input logic [6:0] status);
    aes_status = status;
    aes_done   = 1'b1;
    @(posedge clk);
    #1;
    aes_done = 1'b0;
  endtask

  task automatic applyStimulus(input logic [6:0] status, input int ack_read, output int n);
    ack_on_read = ack_read;
    n = cyc + 1;
    firePulse(status);
  endtask

  task automatic waitCycle(input int t);
    int guard = 0;
    while (cyc + 1 < t && guard < 5000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 5000) noteFail("wait_cycle");
  endtask

  task automatic waitWrites(input int count);
    int guard = 0;
    while (wr_q.size() < count && guard < 500) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 500) noteFail("wait_writes");
  endtask

  task automatic waitIdle(input int limit);
    int guard = 0;
    while (busy !== 1'b0 && guard < limit) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= limit) noteFail("wait_idle");
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"},     32'(busy), 32'd0);
    checkOutput({tag, "_host_ack"}, 32'(host_ack), 32'd0);
    checkOutput({tag, "_timeout"},  32'(timeout), 32'd0);
    checkOutput({tag, "_overflow"}, 32'(overflow), 32'd0);
    checkOutput({tag, "_address"},  32'(mem_address), 32'd0);
    checkOutput({tag, "_cs"},       32'(mem_chipselect), 32'd0);
    checkOutput({tag, "_write"},    32'(mem_write), 32'd0);
    checkOutput({tag, "_wdata"},    32'(mem_writedata), 32'd0);
    checkOutput({tag, "_clken"},    32'(mem_clken), 32'd0);
  endtask

  task automatic runVector(input vec_t v);
    int w0, r0, a0, t0, n, f, endc;
    w0 = wr_q.size();
    r0 = rd_q.size();
    a0 = ack_q.size();
    t0 = to_q.size();
    applyStimulus(v.status, v.ack_read, n);
    checkOutput("busy_rise", 32'(busy), 32'd1);
    waitIdle(400);
    checkOutput("write_count", 32'(wr_q.size() - w0), 32'd2);
    if (wr_q.size() >= w0 + 2) begin
      checkOutput("seq_cycle",  32'(wr_q[w0].cyc - n), 32'd1);
      checkOutput("seq_addr",   32'(wr_q[w0].addr), 32'd1);
      checkOutput("seq_data",   32'(wr_q[w0].data), 32'(v.exp_seq));
      checkOutput("flag_cycle", 32'(wr_q[w0+1].cyc - n), 32'd2);
      checkOutput("flag_addr",  32'(wr_q[w0+1].addr), 32'd0);
      checkOutput("flag_data",  32'(wr_q[w0+1].data), 32'(v.exp_flag));
      f = wr_q[w0+1].cyc;
      checkOutput("read_count", 32'(rd_q.size() - r0), 32'(v.exp_reads));
      if (rd_q.size() > r0)
        checkOutput("first_read", 32'(rd_q[r0] - f), 32'(P));
      checkOutput("ack_count",     32'(ack_q.size() - a0), 32'(v.exp_acks));
      checkOutput("timeout_count", 32'(to_q.size() - t0), 32'(v.exp_tos));
      if (ack_q.size() > a0)      endc = ack_q[a0];
      else if (to_q.size() > t0)  endc = to_q[t0];
      else                        endc = f;
      checkOutput("finish_cycle", 32'(endc - f), 32'(v.exp_reads * (P + 2)));
    end
    checkOutput("flag_mem", 32'(mem[0]), 32'(v.exp_mem0));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, f, w0, a0, b0, tgt;

    vecs[0] = '{7'h15, 3, 8'h00, 8'h95, 3, 1, 0, 8'h00};
    vecs[1] = '{7'h2A, 1, 8'h01, 8'hAA, 1, 1, 0, 8'h00};
    vecs[2] = '{7'h15, 0, 8'h02, 8'h95, 4, 0, 1, 8'h95};
    vecs[3] = '{7'h00, 2, 8'h03, 8'h80, 2, 1, 0, 8'h00};

    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("por");
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("clken_after_reset", 32'(mem_clken), 32'd1);

    for (int i = 0; i < 4; i++) begin
      $display("[TB] vector %0d", i);
      runVector(vecs[i]);
    end

    // Reset while polling: outputs clear at once, RAM keeps its contents.
    w0 = wr_q.size();
    applyStimulus(7'h05, 0, n);
    waitWrites(w0 + 2);
    f = (wr_q.size() >= w0 + 2) ? wr_q[w0+1].cyc : cyc;
    waitCycle(f + 2);
    checkOutput("busy_in_wait", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkResetOutputs("midreset");
    checkOutput("ram_seq_kept",  32'(mem[1]), 32'h04);
    checkOutput("ram_flag_kept", 32'(mem[0]), 32'h85);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("clken_rearmed", 32'(mem_clken), 32'd1);

    // One pending event plus two lost ones while polling.
    w0 = wr_q.size();
    a0 = ack_q.size();
    applyStimulus(7'h11, 2, n);
    waitWrites(w0 + 2);
    f = (wr_q.size() >= w0 + 2) ? wr_q[w0+1].cyc : cyc;
    waitCycle(f + 2);
    firePulse(7'h22);
    checkOutput("ovf_after_first", 32'(overflow), 32'd0);
    waitCycle(f + 4);
    firePulse(7'h33);
    checkOutput("ovf_after_second", 32'(overflow), 32'd1);
    waitCycle(f + 7);
    firePulse(7'h44);
    waitIdle(400);
    checkOutput("pend_write_count", 32'(wr_q.size() - w0), 32'd4);
    if (wr_q.size() >= w0 + 4) begin
      checkOutput("pend_w0", 32'({wr_q[w0].addr,   wr_q[w0].data}),   32'({2'd1, 8'h00}));
      checkOutput("pend_w1", 32'({wr_q[w0+1].addr, wr_q[w0+1].data}), 32'({2'd0, 8'h91}));
      checkOutput("pend_w2", 32'({wr_q[w0+2].addr, wr_q[w0+2].data}), 32'({2'd1, 8'h01}));
      checkOutput("pend_w3", 32'({wr_q[w0+3].addr, wr_q[w0+3].data}), 32'({2'd0, 8'hA2}));
    end
    checkOutput("pend_acks", 32'(ack_q.size() - a0), 32'd2);
    checkOutput("ovf_sticky", 32'(overflow), 32'd1);

    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("ovf_cleared", 32'(overflow), 32'd0);
    @(posedge clk);
    #1;

    // 257 acknowledged events: alternately fired in the acking RD_DATA cycle
    // and in the host_ack cycle; none may be lost.
    b0 = wr_q.size();
    a0 = ack_q.size();
    applyStimulus(7'h00, 1, n);
    for (int k = 1; k <= 256; k++) begin
      waitWrites(b0 + 2 * k);
      f = (wr_q.size() >= b0 + 2 * k) ? wr_q[b0 + 2 * k - 1].cyc : cyc;
      tgt = (k % 2 == 1) ? f + P + 1 : f + P + 2;
      waitCycle(tgt);
      firePulse(7'(k));
    end
    waitIdle(400);
    checkOutput("wrap_write_count", 32'(wr_q.size() - b0), 32'd514);
    for (int i = 0; i < 257; i++) begin
      if (wr_q.size() > b0 + 2 * i)
        checkOutput("wrap_seq", 32'({wr_q[b0 + 2 * i].addr, wr_q[b0 + 2 * i].data}),
                    32'({2'd1, i[7:0]}));
    end
    checkOutput("wrap_acks", 32'(ack_q.size() - a0), 32'd257);
    checkOutput("wrap_no_overflow", 32'(overflow), 32'd0);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
